// File: rtl/latch_bank_wr_sched.sv
// Two-port write sequencer for a bank of latrnq latch words: D setup, single E pulse, D hold.
// Define LATCH_WR_SCHED_CLR_EN to add clear-all sequencing through RN with a recovery gap.
module latch_bank_wr_sched #(
    parameter int WORDS     = 8,
    parameter int WIDTH     = 16,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int CLR_CYC   = 2,
    parameter int REC_CYC   = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     a_req,
    input  logic [$clog2(WORDS)-1:0] a_addr,
    input  logic [WIDTH-1:0]         a_data,
    output logic                     a_ack,
    input  logic                     b_req,
    input  logic [$clog2(WORDS)-1:0] b_addr,
    input  logic [WIDTH-1:0]         b_data,
    output logic                     b_ack,
    input  logic                     clr_req,
    output logic                     clr_ack,
    output logic [WORDS-1:0]         E,
    output logic                     RN,
    output logic [WIDTH-1:0]         D,
    output logic                     busy
);

    localparam int AW = $clog2(WORDS);

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    localparam int MAXC = max2(max2(max2(SETUP_CYC, PULSE_CYC), max2(HOLD_CYC, CLR_CYC)), REC_CYC);
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [WORDS-1:0] E_ONE = WORDS'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD
`ifdef LATCH_WR_SCHED_CLR_EN
        ,
        S_CLR,
        S_REC
`endif
    } state_t;

    state_t            r_state;
    state_t            w_nxt_state;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_nxt_cnt;
    logic              r_rr_last_b;
    logic              r_sel_b;
    logic [AW-1:0]     r_addr;
    logic              w_grant;
    logic              w_grant_b;

    logic [WORDS-1:0]  r_e;
    logic [WIDTH-1:0]  r_d;
    logic              r_a_ack;
    logic              r_b_ack;
    logic              r_busy;
    logic [WORDS-1:0]  w_nxt_e;
    logic [WIDTH-1:0]  w_nxt_d;
    logic              w_nxt_a_ack;
    logic              w_nxt_b_ack;
    logic              w_nxt_busy;

`ifdef LATCH_WR_SCHED_CLR_EN
    logic              r_rn;
    logic              r_clr_ack;
    logic              w_nxt_rn;
    logic              w_nxt_clr_ack;
`else
    logic              w_unused_clr;
    assign w_unused_clr = clr_req;
`endif

    // Next-state: clear beats writes in IDLE; simultaneous writes alternate.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_grant     = 1'b0;
        w_grant_b   = 1'b0;
        case (r_state)
            S_IDLE: begin
`ifdef LATCH_WR_SCHED_CLR_EN
                if (clr_req) begin
                    w_nxt_state = S_CLR;
                    w_nxt_cnt   = CW'(CLR_CYC - 1);
                end else
`endif
                if (a_req || b_req) begin
                    w_grant     = 1'b1;
                    w_grant_b   = b_req && (!a_req || !r_rr_last_b);
                    w_nxt_state = S_SETUP;
                    w_nxt_cnt   = CW'(SETUP_CYC - 1);
                end
            end
            S_SETUP: begin
                if (r_cnt == '0) begin
                    w_nxt_state = S_PULSE;
                    w_nxt_cnt   = CW'(PULSE_CYC - 1);
                end else begin
                    w_nxt_cnt   = r_cnt - CW'(1);
                end
            end
            S_PULSE: begin
                if (r_cnt == '0) begin
                    w_nxt_state = S_HOLD;
                    w_nxt_cnt   = CW'(HOLD_CYC - 1);
                end else begin
                    w_nxt_cnt   = r_cnt - CW'(1);
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt   = r_cnt - CW'(1);
                end
            end
`ifdef LATCH_WR_SCHED_CLR_EN
            S_CLR: begin
                if (r_cnt == '0) begin
                    w_nxt_state = S_REC;
                    w_nxt_cnt   = CW'(REC_CYC - 1);
                end else begin
                    w_nxt_cnt   = r_cnt - CW'(1);
                end
            end
            S_REC: begin
                if (r_cnt == '0) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt   = r_cnt - CW'(1);
                end
            end
`endif
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    always_comb begin
        w_nxt_e     = '0;
        w_nxt_d     = r_d;
        w_nxt_a_ack = 1'b0;
        w_nxt_b_ack = 1'b0;
        w_nxt_busy  = (w_nxt_state != S_IDLE);
        if (w_grant) begin
            w_nxt_d = w_grant_b ? b_data : a_data;
        end
        // An address at or beyond WORDS shifts the one out of range, leaving E all-zero.
        if (w_nxt_state == S_PULSE) begin
            w_nxt_e = E_ONE << r_addr;
        end
        if (w_nxt_state == S_HOLD && w_nxt_cnt == '0) begin
            w_nxt_a_ack = !r_sel_b;
            w_nxt_b_ack = r_sel_b;
        end
`ifdef LATCH_WR_SCHED_CLR_EN
        w_nxt_rn      = 1'b1;
        w_nxt_clr_ack = 1'b0;
        if (w_nxt_state == S_CLR) begin
            w_nxt_rn = 1'b0;
            w_nxt_d  = '0;
        end
        if (w_nxt_state == S_REC && w_nxt_cnt == '0) begin
            w_nxt_clr_ack = 1'b1;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rr_last_b <= 1'b1;
            r_e         <= '0;
            r_d         <= '0;
            r_a_ack     <= 1'b0;
            r_b_ack     <= 1'b0;
            r_busy      <= 1'b0;
`ifdef LATCH_WR_SCHED_CLR_EN
            r_rn        <= 1'b1;
            r_clr_ack   <= 1'b0;
`endif
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            if (w_grant) begin
                r_rr_last_b <= w_grant_b;
            end
            r_e         <= w_nxt_e;
            r_d         <= w_nxt_d;
            r_a_ack     <= w_nxt_a_ack;
            r_b_ack     <= w_nxt_b_ack;
            r_busy      <= w_nxt_busy;
`ifdef LATCH_WR_SCHED_CLR_EN
            r_rn        <= w_nxt_rn;
            r_clr_ack   <= w_nxt_clr_ack;
`endif
        end
    end

    // Captured transaction; only meaningful once a grant has occurred.
    always_ff @(posedge CLK) begin
        if (w_grant) begin
            r_sel_b <= w_grant_b;
            r_addr  <= w_grant_b ? b_addr : a_addr;
        end
    end

    assign E     = r_e;
    assign D     = r_d;
    assign a_ack = r_a_ack;
    assign b_ack = r_b_ack;
    assign busy  = r_busy;
`ifdef LATCH_WR_SCHED_CLR_EN
    assign RN      = r_rn;
    assign clr_ack = r_clr_ack;
`else
    assign RN      = 1'b1;
    assign clr_ack = 1'b0;
`endif

endmodule

// File: tb/tb_latch_bank_wr_sched.sv
// Scoreboard bench for latch_bank_wr_sched: random two-port traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_latch_bank_wr_sched;

    localparam int WORDS = 8;
    localparam int WIDTH = 16;
    localparam int S     = 1;
    localparam int P     = 2;
    localparam int H     = 1;
    localparam int CLRC  = 2;
    localparam int RECC  = 1;
    localparam int AW    = $clog2(WORDS);
    localparam int LAT   = S + P + H;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             a_req = 1'b0, b_req = 1'b0, clr_req = 1'b0;
    logic [AW-1:0]    a_addr = '0, b_addr = '0;
    logic [WIDTH-1:0] a_data = '0, b_data = '0;
    logic             a_ack, b_ack, clr_ack, RN, busy;
    logic [WORDS-1:0] E;
    logic [WIDTH-1:0] D;

    logic             o_a_req = 1'b0, o_b_req = 1'b0, o_clr_req = 1'b0;
    logic [2:0]       o_a_addr = '0, o_b_addr = '0;
    logic [WIDTH-1:0] o_a_data = '0, o_b_data = '0;
    logic             o_a_ack, o_b_ack, o_clr_ack, o_RN, o_busy;
    logic [4:0]       o_E;
    logic [WIDTH-1:0] o_D;

    latch_bank_wr_sched #(.WORDS(WORDS), .WIDTH(WIDTH), .SETUP_CYC(S), .PULSE_CYC(P),
                          .HOLD_CYC(H), .CLR_CYC(CLRC), .REC_CYC(RECC)) u_dut (
        .CLK(CLK), .RST(RST),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
        .clr_req(clr_req), .clr_ack(clr_ack), .E(E), .RN(RN), .D(D), .busy(busy));

    // Five words in a 3-bit address space leaves 5..7 out of range.
    latch_bank_wr_sched #(.WORDS(5), .WIDTH(WIDTH), .SETUP_CYC(S), .PULSE_CYC(P),
                          .HOLD_CYC(H), .CLR_CYC(CLRC), .REC_CYC(RECC)) u_oor (
        .CLK(CLK), .RST(RST),
        .a_req(o_a_req), .a_addr(o_a_addr), .a_data(o_a_data), .a_ack(o_a_ack),
        .b_req(o_b_req), .b_addr(o_b_addr), .b_data(o_b_data), .b_ack(o_b_ack),
        .clr_req(o_clr_req), .clr_ack(o_clr_ack), .E(o_E), .RN(o_RN), .D(o_D), .busy(o_busy));

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic             b;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
        int unsigned      t;
    } exp_t;

    exp_t        sb[$];
    bit          mon_en    = 1'b0;
    int unsigned next_free = 0;
    bit          rr_b      = 1'b1;
    int          a_st = 0, b_st = 0;

    // Monitor: per-cycle invariants, and a scoreboard pop on every ack.
    initial begin
        int unsigned      rise_cyc, e_len, last_fall;
        logic [WORDS-1:0] e_word, ex_e;
        logic [WIDTH-1:0] d_pulse;
        bit               seen_fall, prev_hi;
        exp_t             x;
        rise_cyc = 0; e_len = 0; last_fall = 0; e_word = '0; d_pulse = '0;
        seen_fall = 1'b0; prev_hi = 1'b0;
        forever begin
            @(negedge CLK);
            if (!mon_en) begin
                e_len = 0; e_word = '0; seen_fall = 1'b0; prev_hi = 1'b0;
                continue;
            end
            check_eq("e_onehot", 64'($countones(E) <= 1), 1);
            check_eq("rn_high", RN, 1);
            if (E != '0) begin
                if (!prev_hi) begin
                    rise_cyc = cyc;
                    e_word   = E;
                    d_pulse  = D;
                    if (seen_fall) check_eq("e_gap_ok", 64'((rise_cyc - last_fall) >= S + 1), 1);
                end
                e_len++;
                prev_hi = 1'b1;
            end else begin
                if (prev_hi) begin
                    last_fall = cyc;
                    seen_fall = 1'b1;
                end
                prev_hi = 1'b0;
            end
            if (a_ack || b_ack) begin
                check_eq("ack_single", a_ack && b_ack, 0);
                check_eq("sb_nonempty", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    x = sb.pop_front();
                    ex_e = '0;
                    ex_e[x.addr] = 1'b1;
                    check_eq("ack_port_b", b_ack, x.b);
                    check_eq("ack_cycle", cyc, x.t + LAT - 1);
                    check_eq("d_at_ack", D, x.data);
                    check_eq("e_word", e_word, ex_e);
                    check_eq("e_len", e_len, P);
                    check_eq("e_rise", rise_cyc, x.t + S);
                    check_eq("d_in_pulse", d_pulse, x.data);
                end
                e_len  = 0;
                e_word = '0;
            end
        end
    end

    // One driver step per cycle: model the grant at the edge just passed, then update requesters.
    task automatic run_phase(input int ncyc, input int pct, input bit fixed,
                             input logic [AW-1:0] fa, input logic [AW-1:0] fb, input bit drops);
        exp_t x;
        bit   pick_b;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge CLK);
            #1;
            if (cyc >= next_free && (a_req || b_req)) begin
                pick_b = (a_req && b_req) ? !rr_b : b_req;
                x.b    = pick_b;
                x.addr = pick_b ? b_addr : a_addr;
                x.data = pick_b ? b_data : a_data;
                x.t    = cyc;
                sb.push_back(x);
                rr_b      = pick_b;
                next_free = cyc + LAT + 1;
                if (pick_b) b_st = 2; else a_st = 2;
                if (drops && $urandom_range(0, 3) == 0) begin
                    if (pick_b) begin b_req = 1'b0; b_data = WIDTH'($urandom); end
                    else        begin a_req = 1'b0; a_data = WIDTH'($urandom); end
                end
            end
            if (a_ack) begin a_st = 0; a_req = 1'b0; end
            if (b_ack) begin b_st = 0; b_req = 1'b0; end
            if (a_st == 0 && $urandom_range(1, 100) <= pct) begin
                a_st = 1; a_req = 1'b1;
                a_addr = fixed ? fa : AW'($urandom_range(0, WORDS - 1));
                a_data = WIDTH'($urandom);
            end
            if (b_st == 0 && $urandom_range(1, 100) <= pct) begin
                b_st = 1; b_req = 1'b1;
                b_addr = fixed ? fb : AW'($urandom_range(0, WORDS - 1));
                b_data = WIDTH'($urandom);
            end
        end
    endtask

    initial begin
        int unsigned c0, ack_cyc, rise_c, clr_c, rn_low;
        bit          e_any, b_seen, seen, viol, rn_was_low, clr_done;
        logic [WIDTH-1:0] dv, d_ack;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_E", E, 0);
        check_eq("rst_RN", RN, 1);
        check_eq("rst_D", D, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_acks", {a_ack, b_ack, clr_ack}, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check_eq("idle_outputs", {E, RN, D, busy, a_ack, b_ack, clr_ack}, {8'h00, 1'b1, 16'h0000, 4'b0000});
        end
        mon_en = 1'b1;

        @(posedge CLK); #1;
        a_req = 1'b1; a_addr = 3; a_data = 16'hA5C3; a_st = 1;
        run_phase(8, 0, 1'b0, '0, '0, 1'b0);
        run_phase(60, 100, 1'b1, AW'(1), AW'(6), 1'b0);
        run_phase(3000, 30, 1'b0, '0, '0, 1'b1);
        run_phase(20, 0, 1'b0, '0, '0, 1'b0);
        check_eq("sb_drained", sb.size(), 0);
        check_eq("ports_idle", {a_st[1:0], b_st[1:0]}, 0);

        // Reset during the E pulse
        mon_en = 1'b0;
        @(posedge CLK); #1;
        a_req = 1'b1; a_addr = 3; a_data = WIDTH'($urandom);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            if (E == 8'h08) seen = 1'b1;
        end
        check_eq("pulse_seen", seen, 1);
        RST = 1'b1; a_req = 1'b0;
        @(posedge CLK); #1;
        check_eq("midrst_E", E, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_ack", a_ack, 0);
        check_eq("midrst_D", D, 0);
        RST = 1'b0;
        viol = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (a_ack || b_ack || E != '0) viol = 1'b1;
        end
        check_eq("midrst_quiet", viol, 0);

        // Out-of-range address on the five-word instance
        @(posedge CLK); #1;
        c0 = cyc;
        dv = WIDTH'($urandom);
        o_a_req = 1'b1; o_a_addr = 3'd6; o_a_data = dv;
        e_any = 1'b0; b_seen = 1'b0; ack_cyc = 0; d_ack = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (o_E != '0) e_any = 1'b1;
            if (o_b_ack) b_seen = 1'b1;
            if (o_a_ack && ack_cyc == 0) begin
                ack_cyc = cyc; d_ack = o_D; o_a_req = 1'b0;
            end
        end
        check_eq("oor_E_zero", e_any, 0);
        check_eq("oor_ack_cycle", ack_cyc, c0 + LAT);
        check_eq("oor_D", d_ack, dv);
        check_eq("oor_no_b_ack", b_seen, 0);

`ifdef LATCH_WR_SCHED_CLR_EN
        // Clear and write requested together: clear first, then the write
        @(posedge CLK); #1;
        c0 = cyc;
        dv = WIDTH'($urandom);
        clr_req = 1'b1; a_req = 1'b1; a_addr = 2; a_data = dv;
        rn_low = 0; clr_c = 0; rise_c = 0; ack_cyc = 0;
        viol = 1'b0; rn_was_low = 1'b0; clr_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (RN == 1'b0) begin
                rn_low++; rn_was_low = 1'b1;
                if (D != '0) viol = 1'b1;
            end
            if (E != '0 && (RN == 1'b0 || (rn_was_low && !clr_done))) viol = 1'b1;
            if (clr_ack && clr_c == 0) begin clr_c = cyc; clr_done = 1'b1; clr_req = 1'b0; end
            if (E != '0 && rise_c == 0) rise_c = cyc;
            if (a_ack && ack_cyc == 0) begin ack_cyc = cyc; a_req = 1'b0; end
        end
        check_eq("clr_rn_low", rn_low, CLRC);
        check_eq("clr_ack_cycle", clr_c, c0 + CLRC + RECC);
        check_eq("clr_e_quiet", viol, 0);
        check_eq("clr_wr_rise", rise_c, c0 + CLRC + RECC + 2 + S);
        check_eq("clr_wr_ack", ack_cyc, c0 + CLRC + RECC + 2 + LAT - 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
